xnor_eq_sched: RTL

XNOR_EQ_SCHED -- requirements
Module: xnor_eq_sched

---
 rtl/xnor_eq_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/xnor_eq_sched.sv
// Two-requester bitwise equality checker sharing one 1-bit XNOR stage, LSB first.
// Optional early exit on the first mismatching bit: define XNOR_EQ_EARLY_EXIT_EN.
`timescale 1ns/1ps
module xnor_eq_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_eq,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_q, eq_d;
  logic             id_q, id_d;
  // prio_q = 1 means req1 wins a tie; cleared on reset so req0 goes first.
  logic             prio_q, prio_d;

  logic grant0, grant1;
  logic bit_eq;
  logic last_bit;
  logic stop_shift;

  // Readies are also gated by rst_n so they drop the instant reset asserts.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign bit_eq   = ~(sa_q[0] ^ sb_q[0]);
  assign last_bit = (cnt_q == LAST_BIT);

`ifdef XNOR_EQ_EARLY_EXIT_EN
  assign stop_shift = last_bit | ~bit_eq;
`else
  assign stop_shift = last_bit;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    id_d    = id_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          sa_d    = grant1 ? req1_a : req0_a;
          sb_d    = grant1 ? req1_b : req0_b;
          eq_d    = 1'b1;
          cnt_d   = '0;
          id_d    = grant1;
          prio_d  = ~grant1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        eq_d  = eq_q & bit_eq;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (stop_shift) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_eq     = rsp_valid & eq_q;
  assign rsp_id     = rsp_valid & id_q;
  assign busy       = (state_q != IDLE);

endmodule
